// File: rtl/pc_add.sv
// Program-counter incrementer: combinational pc+4 with carry/misalign flags,
// plus a single capture stage holding the PC, its successor and a valid bit.
package pc_add_pkg;
  localparam int XLEN = 32;
endpackage

module pc_add
  import pc_add_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  en_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  wrap_o,
  output logic                  misalign_o,
  output logic [DATA_WIDTH-1:0] pc_q_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_q_o,
  output logic                  valid_q_o
);

  // Sum carries one extra bit so the carry-out becomes the wrap flag.
  function automatic logic [DATA_WIDTH:0] add4(input logic [DATA_WIDTH-1:0] pc);
    logic [DATA_WIDTH:0] four;
    four = (DATA_WIDTH+1)'(4);
    return {1'b0, pc} + four;
  endfunction

  logic [DATA_WIDTH:0]   sum_p0;
  logic [DATA_WIDTH-1:0] pc_p1;
  logic [DATA_WIDTH-1:0] pc_plus4_p1;
  logic                  vld_p1;

  always_comb begin
    sum_p0 = add4(pc_i);
  end

  assign pc_plus4_o = sum_p0[DATA_WIDTH-1:0];
  assign wrap_o     = sum_p0[DATA_WIDTH];
  assign misalign_o = |pc_i[1:0];

  // ---- stage p0 -> p1 ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p1       <= '0;
      pc_plus4_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (flush_i) begin
      vld_p1      <= 1'b0;
    end else if (en_i) begin
      pc_p1       <= pc_i;
      pc_plus4_p1 <= sum_p0[DATA_WIDTH-1:0];
      vld_p1      <= 1'b1;
    end
  end

  assign pc_q_o       = pc_p1;
  assign pc_plus4_q_o = pc_plus4_p1;
  assign valid_q_o    = vld_p1;

endmodule

// File: tb/tb_pc_add.sv
// Directed bench for pc_add: combinational increment/flags, then capture,
// hold, flush priority and asynchronous reset of the registered stage.
module tb_pc_add;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] pc_i;
  logic         en_i;
  logic         flush_i;
  logic [W-1:0] pc_plus4_o;
  logic         wrap_o;
  logic         misalign_o;
  logic [W-1:0] pc_q_o;
  logic [W-1:0] pc_plus4_q_o;
  logic         valid_q_o;
  logic         clk_run = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  pc_add #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_i         (pc_i),
    .en_i         (en_i),
    .flush_i      (flush_i),
    .pc_plus4_o   (pc_plus4_o),
    .wrap_o       (wrap_o),
    .misalign_o   (misalign_o),
    .pc_q_o       (pc_q_o),
    .pc_plus4_q_o (pc_plus4_q_o),
    .valid_q_o    (valid_q_o)
  );

  // Clock stays undriven until the combinational checks are done.
  initial begin
    wait (clk_run);
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic comb(input logic [W-1:0] pc, input logic [W-1:0] exp_sum,
                      input logic exp_wrap, input logic exp_mis, input string tag);
    pc_i = pc;
    #1;
    check({tag, "_sum"}, 64'(pc_plus4_o), 64'(exp_sum));
    check({tag, "_wrap"}, 64'(wrap_o), 64'(exp_wrap));
    check({tag, "_mis"}, 64'(misalign_o), 64'(exp_mis));
  endtask

  task automatic regs(input logic [W-1:0] exp_pc, input logic [W-1:0] exp_p4,
                      input logic exp_v, input string tag);
    check({tag, "_pc_q"}, 64'(pc_q_o), 64'(exp_pc));
    check({tag, "_p4_q"}, 64'(pc_plus4_q_o), 64'(exp_p4));
    check({tag, "_vld_q"}, 64'(valid_q_o), 64'(exp_v));
  endtask

  initial begin
    // Combinational path with clk, rst_n, en_i, flush_i all undriven.
    comb(32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0, "zero");
    comb(32'd100,       32'd104,       1'b0, 1'b0, "hundred");
    comb(32'hABCD_1234, 32'hABCD_1238, 1'b0, 1'b0, "abcd");
    comb(32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 1'b1, "below_wrap");
    comb(32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0, "wrap_fc");
    comb(32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 1'b1, "wrap_ff");
    comb(32'h0000_0102, 32'h0000_0106, 1'b0, 1'b1, "mis2");

    // Asynchronous reset with no clock running.
    en_i = 1'b0;
    flush_i = 1'b0;
    rst_n = 1'b0;
    #1;
    regs('0, '0, 1'b0, "rst_noclk");

    clk_run = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    en_i = 1'b1;
    pc_i = 32'h0000_1000;
    #1;
    regs('0, '0, 1'b0, "pre_capture");
    @(posedge clk); #1;
    regs(32'h1000, 32'h1004, 1'b1, "capture");

    // Hold with en low while pc changes.
    @(negedge clk);
    en_i = 1'b0;
    pc_i = 32'h0000_2000;
    #1;
    check("hold_comb", 64'(pc_plus4_o), 64'h2004);
    @(posedge clk); #1;
    regs(32'h1000, 32'h1004, 1'b1, "hold");

    @(negedge clk);
    en_i = 1'b1;
    pc_i = 32'h0000_3000;
    @(posedge clk); #1;
    regs(32'h3000, 32'h3004, 1'b1, "capture2");

    // Flush wins over enable.
    @(negedge clk);
    flush_i = 1'b1;
    pc_i = 32'h0000_4000;
    @(posedge clk); #1;
    regs(32'h3000, 32'h3004, 1'b0, "flush_pri");

    @(negedge clk);
    flush_i = 1'b0;
    en_i = 1'b0;
    @(posedge clk); #1;
    regs(32'h3000, 32'h3004, 1'b0, "idle_after_flush");

    @(negedge clk);
    en_i = 1'b1;
    pc_i = 32'h0000_5002;
    @(posedge clk); #1;
    regs(32'h5002, 32'h5006, 1'b1, "capture_mis");

    // Reset between edges clears immediately; comb path keeps tracking.
    #2;
    rst_n = 1'b0;
    #1;
    regs('0, '0, 1'b0, "mid_reset");
    pc_i = 32'h0000_6000;
    #1;
    check("rst_comb", 64'(pc_plus4_o), 64'h6004);
    @(posedge clk); #1;
    regs('0, '0, 1'b0, "reset_edge");

    @(negedge clk);
    rst_n = 1'b1;
    pc_i = 32'h0000_7000;
    @(posedge clk); #1;
    regs(32'h7000, 32'h7004, 1'b1, "post_reset");

    @(negedge clk);
    pc_i = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    regs(32'hFFFF_FFFE, 32'h0000_0002, 1'b1, "capture_wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_add.md
PC_ADD -- requirements
Module: pc_add

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32 (from the defines package), giving the PC and data width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all registered state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port pc_i, input, DATA_WIDTH, current program counter.
REQ-005 SHALL have port en_i, input, 1, capture enable for the registered stage.
REQ-006 SHALL have port flush_i, input, 1, invalidates the registered stage.
REQ-007 SHALL have port pc_plus4_o, output, DATA_WIDTH, combinational pc_i + 4.
REQ-008 SHALL have port wrap_o, output, 1, combinational carry-out of pc_i + 4.
REQ-009 SHALL have port misalign_o, output, 1, combinational flag, pc_i[1:0] != 0.
REQ-010 SHALL have port pc_q_o, output, DATA_WIDTH, registered copy of pc_i.
REQ-011 SHALL have port pc_plus4_q_o, output, DATA_WIDTH, registered copy of pc_plus4_o.
REQ-012 SHALL have port valid_q_o, output, 1, registered stage holds a valid captured PC.

Function
REQ-013 pc_plus4_o SHALL equal (pc_i + 4) mod 2^DATA_WIDTH, purely combinational, zero cycles latency.
REQ-014 pc_plus4_o, wrap_o and misalign_o SHALL depend only on pc_i; they are independent of clk, rst_n, en_i and flush_i.
REQ-015 These outputs SHALL be correct even when clk, rst_n, en_i and flush_i are left undriven.
REQ-016 Wrap-around: pc_i >= 2^DATA_WIDTH - 4 SHALL produce the truncated sum and wrap_o = 1; otherwise wrap_o = 0.
REQ-017 Wrap example: pc_i = 0xFFFF_FFFC gives pc_plus4_o = 0x0000_0000; pc_i = 0xFFFF_FFFF gives 0x0000_0003.
REQ-018 misalign_o SHALL be informational only and SHALL NOT alter pc_plus4_o.
REQ-019 On a rising clk edge with flush_i = 1, valid_q_o SHALL become 0; pc_q_o and pc_plus4_q_o SHALL hold their values.
REQ-020 On a rising clk edge with flush_i = 0 and en_i = 1: pc_q_o <= pc_i, pc_plus4_q_o <= pc_i + 4, valid_q_o <= 1.
REQ-021 On a rising clk edge with flush_i = 0 and en_i = 0, all registered outputs SHALL hold.
REQ-022 flush_i SHALL take priority over en_i when both are asserted.
REQ-023 Registered outputs SHALL have exactly one cycle of latency from pc_i.
REQ-024 No X SHALL propagate to the registered outputs while rst_n = 0.

Reset
REQ-025 While rst_n = 0, asynchronously and regardless of clk: pc_q_o = 0, pc_plus4_q_o = 0, valid_q_o = 0.
REQ-026 Reset SHALL NOT affect the combinational outputs (REQ-013..REQ-018).
REQ-027 Reset asserted mid-operation SHALL clear the registered outputs immediately.
REQ-028 After rst_n deasserts, the first rising edge with en_i = 1 SHALL capture normally.

Verification
REQ-029 pc_i = 0 -> pc_plus4_o = 4, wrap_o = 0, misalign_o = 0; clk and rst_n undriven.
REQ-030 pc_i = 100 -> 104; pc_i = 0xABCD_1234 -> 0xABCD_1238; each checked 1 ns after the change.
REQ-031 pc_i = 0xFFFF_FFFC -> pc_plus4_o = 0, wrap_o = 1; pc_i = 0xFFFF_FFFF -> 3, wrap_o = 1, misalign_o = 1.
REQ-032 Capture and hold: rst_n = 1, en_i = 1, pc_i = 0x1000, one edge -> pc_q_o = 0x1000, pc_plus4_q_o = 0x1004, valid_q_o = 1; then en_i = 0 with pc_i changed -> registered outputs hold.
REQ-033 Flush priority: en_i = 1 and flush_i = 1 on one edge -> valid_q_o = 0, pc_q_o unchanged.
REQ-034 Mid-operation reset: rst_n = 0 between clock edges -> registered outputs 0 immediately, while pc_plus4_o still tracks pc_i.
